tap_ctrl: RTL

TAP_CTRL -- requirements
Module: tap_ctrl

---
 rtl/tap_ctrl_if.sv | 18 +
 rtl/tap_ctrl.sv | 95 +++++++++
 2 files changed

// File: rtl/tap_ctrl_if.sv
// tap_ctrl_if: TAP pins plus boundary-scan control strobes
interface tap_ctrl_if;
  logic       TMS;
  logic       TDI;
  logic       bsr_tdo;
  logic       TDO;
  logic       tdo_en;
  logic       dr_capture;
  logic       dr_shift;
  logic       dr_update;
  logic       bsr_select;
  logic       mode;
  logic [3:0] tap_state;
  modport master (output TMS, TDI, bsr_tdo,
                  input TDO, tdo_en, dr_capture, dr_shift, dr_update, bsr_select, mode, tap_state);
  modport slave (input TMS, TDI, bsr_tdo,
                 output TDO, tdo_en, dr_capture, dr_shift, dr_update, bsr_select, mode, tap_state);
endinterface

// File: rtl/tap_ctrl.sv
// tap_ctrl: 16-state TAP controller with instruction, bypass and IDCODE registers
module tap_ctrl #(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input logic       TCK,
  input logic       TRST,
  tap_ctrl_if.slave tap
);
  typedef enum logic [3:0] {
    TLR = 4'hF, RTI = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6, SHIFT_DR = 4'h2, EXIT1_DR = 4'h1,
    PAUSE_DR = 4'h3, EXIT2_DR = 4'h0, UPDATE_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE,
    SHIFT_IR = 4'hA, EXIT1_IR = 4'h9, PAUSE_IR = 4'hB, EXIT2_IR = 4'h8, UPDATE_IR = 4'hD
  } state_t;
  localparam logic [IR_WIDTH-1:0] I_EXTEST = '0;
  localparam logic [IR_WIDTH-1:0] I_SAMPLE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] I_IDCODE = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] IR_CAP   = IR_WIDTH'(1);
  state_t              state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d, ir_sh_q;
  logic [31:0]         id_q;
  logic                byp_q;
  logic                dr_capture_q, dr_shift_q, dr_update_q, bsr_select_q, mode_q, tdo_en_q;
  logic                bsr_sel, idc_sel;
  assign bsr_sel = ir_q == I_EXTEST || ir_q == I_SAMPLE;
  assign idc_sel = ir_q == I_IDCODE;
  // next TAP state from current state and TMS
  always_comb begin
    state_d = TLR;
    case (state_q)
      TLR:                  state_d = tap.TMS ? TLR       : RTI;
      RTI:                  state_d = tap.TMS ? SEL_DR    : RTI;
      SEL_DR:               state_d = tap.TMS ? SEL_IR    : CAP_DR;
      SEL_IR:               state_d = tap.TMS ? TLR       : CAP_IR;
      CAP_DR, SHIFT_DR:     state_d = tap.TMS ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:             state_d = tap.TMS ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:             state_d = tap.TMS ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:             state_d = tap.TMS ? UPDATE_DR : SHIFT_DR;
      CAP_IR, SHIFT_IR:     state_d = tap.TMS ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:             state_d = tap.TMS ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:             state_d = tap.TMS ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:             state_d = tap.TMS ? UPDATE_IR : SHIFT_IR;
      UPDATE_DR, UPDATE_IR: state_d = tap.TMS ? SEL_DR    : RTI;
      default:              state_d = TLR;
    endcase
  end
  // entering or sitting in TLR forces IDCODE; leaving UPDATE_IR commits the shifted instruction
  assign ir_d = state_d == TLR ? I_IDCODE : state_q == UPDATE_IR ? ir_sh_q : ir_q;
  // state, active instruction and strobes registered from next-state so outputs never see TMS directly
  always_ff @(posedge TCK or posedge TRST)
    if (TRST) begin
      state_q      <= TLR;
      ir_q         <= I_IDCODE;
      dr_capture_q <= 1'b0;
      dr_shift_q   <= 1'b0;
      dr_update_q  <= 1'b0;
      bsr_select_q <= 1'b0;
      mode_q       <= 1'b0;
      tdo_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      dr_capture_q <= state_d == CAP_DR || state_d == SHIFT_DR;
      dr_shift_q   <= state_d == SHIFT_DR;
      dr_update_q  <= state_d == UPDATE_DR;
      bsr_select_q <= ir_d == I_EXTEST || ir_d == I_SAMPLE;
      mode_q       <= ir_d == I_EXTEST;
      tdo_en_q     <= state_d == SHIFT_DR || state_d == SHIFT_IR;
    end
  // IR shift, bypass and ID data registers act on the state being left
  always_ff @(posedge TCK or posedge TRST)
    if (TRST) begin
      ir_sh_q <= IR_CAP;
      byp_q   <= 1'b0;
      id_q    <= IDCODE_VAL;
    end else begin
      if (state_q == CAP_IR) ir_sh_q <= IR_CAP;
      else if (state_q == SHIFT_IR) ir_sh_q <= {tap.TDI, ir_sh_q[IR_WIDTH-1:1]};
      if (state_q == CAP_DR) begin
        byp_q <= 1'b0;
        id_q  <= IDCODE_VAL;
      end else if (state_q == SHIFT_DR) begin
        if (!bsr_sel && !idc_sel) byp_q <= tap.TDI;
        if (idc_sel) id_q <= {tap.TDI, id_q[31:1]};
      end
    end
  assign tap.TDO        = state_q == SHIFT_IR ? ir_sh_q[0] : bsr_sel ? tap.bsr_tdo : idc_sel ? id_q[0] : byp_q;
  assign tap.tdo_en     = tdo_en_q;
  assign tap.dr_capture = dr_capture_q;
  assign tap.dr_shift   = dr_shift_q;
  assign tap.dr_update  = dr_update_q;
  assign tap.bsr_select = bsr_select_q;
  assign tap.mode       = mode_q;
  assign tap.tap_state  = state_q;
endmodule
